// File: rtl/fa_bist.sv
// Built-in self-test engine for a 1-bit full adder: sweeps all eight input vectors,
// checks {co,res} and records pass/fail, a saturating error count and the first failure.
// Optional macro FA_BIST_LOOP_EN: sweep indefinitely until a start pulse while busy stops the run.
module fa_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bistStart,
  output logic       bistOp1,
  output logic       bistOp2,
  output logic       bistCi,
  input  logic       bistRes,
  input  logic       bistCo,
  output logic       bistBusy,
  output logic       bistDone,
  output logic       bistPass,
  output logic [3:0] bistErrCnt,
  output logic [2:0] bistFailVec,
  output logic [1:0] bistFailGot
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] drv_q, drv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ok_q, ok_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fvec_q, fvec_d;
  logic [1:0] fgot_q, fgot_d;
  logic [1:0] got;
`ifdef FA_BIST_LOOP_EN
  logic       stop_q, stop_d;
`else
  logic [3:0] pass_q, pass_d;
`endif

  function automatic logic [1:0] exp_sum(input logic [2:0] v);
    return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ok_d    = ok_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fgot_d  = fgot_q;
`ifdef FA_BIST_LOOP_EN
    stop_d  = stop_q;
`else
    pass_d  = pass_q;
`endif
    got     = {bistCo, bistRes};

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bistStart) begin
          vec_d   = 3'd0;
          err_d   = 4'd0;
          fvec_d  = 3'd0;
          fgot_d  = 2'd0;
          done_d  = 1'b0;
          ok_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
`ifdef FA_BIST_LOOP_EN
          stop_d  = 1'b0;
`else
          pass_d  = 4'd0;
`endif
        end
      end

      ST_SETTLE: begin
`ifdef FA_BIST_LOOP_EN
        if (bistStart) stop_d = 1'b1;
`endif
        if (cnt_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CHECK: begin
        if (got != exp_sum(vec_q)) begin
          if (err_q == 4'd0) begin
            fvec_d = vec_q;
            fgot_d = got;
          end
          err_d = sat_inc(err_q);
        end
        cnt_d = SETTLE_LD;
`ifdef FA_BIST_LOOP_EN
        // A stop request seen during this vector ends the run only after it is checked.
        if (stop_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ok_d    = (err_d == 4'd0);
          state_d = ST_DONE;
        end else begin
          if (bistStart) stop_d = 1'b1;
          vec_d   = vec_q + 3'd1;
          state_d = ST_SETTLE;
        end
`else
        if (vec_q != 3'd7) begin
          vec_d   = vec_q + 3'd1;
          state_d = ST_SETTLE;
        end else if (pass_q < 4'(PASSES - 1)) begin
          vec_d   = 3'd0;
          pass_d  = pass_q + 4'd1;
          state_d = ST_SETTLE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ok_d    = (err_d == 4'd0);
          state_d = ST_DONE;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    // Adder inputs carry the vector only while a run is active.
    if (state_d == ST_SETTLE || state_d == ST_CHECK) begin
      drv_d = vec_d;
    end else begin
      drv_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      vec_q   <= 3'd0;
      drv_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 4'd0;
      fvec_q  <= 3'd0;
      fgot_q  <= 2'd0;
`ifdef FA_BIST_LOOP_EN
      stop_q  <= 1'b0;
`else
      pass_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fgot_q  <= fgot_d;
`ifdef FA_BIST_LOOP_EN
      stop_q  <= stop_d;
`else
      pass_q  <= pass_d;
`endif
    end
  end

  assign bistOp1     = drv_q[2];
  assign bistOp2     = drv_q[1];
  assign bistCi      = drv_q[0];
  assign bistBusy    = busy_q;
  assign bistDone    = done_q;
  assign bistPass    = ok_q;
  assign bistErrCnt  = err_q;
  assign bistFailVec = fvec_q;
  assign bistFailGot = fgot_q;

endmodule

// File: tb/tb_fa_bist.sv
// Bench for fa_bist: three engines (S/P = 1/1, 1/3, 3/1) driving behavioural adders with
// selectable faults, checked every cycle against a run-level model plus literal expectations.
module tb_fa_bist;

`ifdef FA_BIST_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] rst_v, start_v, op1, op2, ci, res, co, busy, done, pass;
  logic [3:0] err  [3];
  logic [2:0] fvec [3];
  logic [1:0] fgot [3];
  int         fault [3];
  logic       cmp_en = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;

  function automatic int s_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int p_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic logic [1:0] golden(input logic [2:0] x);
    int k;
    k = int'(x[2]) + int'(x[1]) + int'(x[0]);
    return 2'(k);
  endfunction

  // Fault 0: good adder; 1: carry stuck-at-0; 2: inverted sum.
  function automatic logic [1:0] adder(input int f, input logic [2:0] x);
    logic [1:0] r;
    r = golden(x);
    if (f == 1) r[1] = 1'b0;
    if (f == 2) r[0] = ~r[0];
    return r;
  endfunction

  assign {co[0], res[0]} = adder(fault[0], {op1[0], op2[0], ci[0]});
  assign {co[1], res[1]} = adder(fault[1], {op1[1], op2[1], ci[1]});
  assign {co[2], res[2]} = adder(fault[2], {op1[2], op2[2], ci[2]});

  fa_bist #(.SETTLE_CYCLES(1), .PASSES(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .bistStart(start_v[0]),
    .bistOp1(op1[0]), .bistOp2(op2[0]), .bistCi(ci[0]),
    .bistRes(res[0]), .bistCo(co[0]),
    .bistBusy(busy[0]), .bistDone(done[0]), .bistPass(pass[0]),
    .bistErrCnt(err[0]), .bistFailVec(fvec[0]), .bistFailGot(fgot[0])
  );

  fa_bist #(.SETTLE_CYCLES(1), .PASSES(3)) u1 (
    .clk(clk), .rst(rst_v[1]), .bistStart(start_v[1]),
    .bistOp1(op1[1]), .bistOp2(op2[1]), .bistCi(ci[1]),
    .bistRes(res[1]), .bistCo(co[1]),
    .bistBusy(busy[1]), .bistDone(done[1]), .bistPass(pass[1]),
    .bistErrCnt(err[1]), .bistFailVec(fvec[1]), .bistFailGot(fgot[1])
  );

  fa_bist #(.SETTLE_CYCLES(3), .PASSES(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .bistStart(start_v[2]),
    .bistOp1(op1[2]), .bistOp2(op2[2]), .bistCi(ci[2]),
    .bistRes(res[2]), .bistCo(co[2]),
    .bistBusy(busy[2]), .bistDone(done[2]), .bistPass(pass[2]),
    .bistErrCnt(err[2]), .bistFailVec(fvec[2]), .bistFailGot(fgot[2])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d at cycle %0d: got %0h, expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Run model: state (0 idle, 1 running, 2 done), cycles since start, captured fault, stop point.
  int mst [3];
  int mt [3];
  int mf [3];
  int mstop [3];

  function automatic int end_t(input int i, input int stp);
    if (LOOP) return (stp == 0) ? -1 : stp;
    return 8 * (s_of(i) + 1) * p_of(i);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin
        mst[i] <= 0;
      end else if (start_v[i] && mst[i] != 1) begin
        mst[i]   <= 1;
        mt[i]    <= 0;
        mf[i]    <= fault[i];
        mstop[i] <= 0;
      end else if (mst[i] == 1) begin
        if (LOOP && start_v[i] && mstop[i] == 0)
          mstop[i] <= ((mt[i] + 1) / (s_of(i) + 1) + 1) * (s_of(i) + 1);
        mt[i] <= mt[i] + 1;
        if (mt[i] + 1 == end_t(i, mstop[i])) mst[i] <= 2;
      end
    end
  end

  // Vector n of the run is checked once t reaches (n+1)*(S+1) cycles after start.
  task automatic model_out(input int s, input int f, input int t, input int st,
                           output logic [2:0] v, output logic b, output logic d, output logic p,
                           output logic [3:0] e, output logic [2:0] fv, output logic [1:0] fg);
    int c, errs;
    logic [2:0] x;
    v = 3'd0; b = 1'b0; d = 1'b0; p = 1'b0; e = 4'd0; fv = 3'd0; fg = 2'd0;
    if (st == 0) return;
    c = t / (s + 1);
    errs = 0;
    for (int n = 0; n < c; n++) begin
      x = 3'(n % 8);
      if (adder(f, x) != golden(x)) begin
        if (errs == 0) begin
          fv = x;
          fg = adder(f, x);
        end
        errs++;
      end
    end
    e = (errs > 15) ? 4'd15 : 4'(errs);
    if (st == 1) begin
      b = 1'b1;
      v = 3'((t / (s + 1)) % 8);
    end else begin
      d = 1'b1;
      p = (errs == 0);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [2:0] ev, efv;
        logic       eb, ed, ep;
        logic [3:0] ee;
        logic [1:0] efg;
        model_out(s_of(i), mf[i], mt[i], mst[i], ev, eb, ed, ep, ee, efv, efg);
        chk("vector", i, {op1[i], op2[i], ci[i]}, ev);
        chk("busy", i, busy[i], eb);
        chk("done", i, done[i], ed);
        chk("pass", i, pass[i], ep);
        chk("errcnt", i, err[i], ee);
        chk("failvec", i, fvec[i], efv);
        chk("failgot", i, fgot[i], efg);
      end
    end
  end

  task automatic kick(input int i, output int k);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int i, input int k, output int el);
    int n;
    n = 0;
    while (!done[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", i, done[i], 1);
    el = cyc - k;
  endtask

  initial begin
    int k, el;
    rst_v    = 3'b111;
    start_v  = 3'b000;
    fault[0] = 0;
    fault[1] = 2;
    fault[2] = 0;
    repeat (2) @(negedge clk);
    rst_v  = 3'b000;
    cmp_en = 1'b1;
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_done", 0, done[0], 0);
    chk("rst_err", 0, err[0], 0);

    if (!LOOP) begin
      kick(0, k);
      wait_done(0, k, el);
      chk("len_good", 0, el, 16);
      chk("pass_good", 0, pass[0], 1);
      chk("err_good", 0, err[0], 0);

      fault[0] = 1;
      kick(0, k);
      wait_done(0, k, el);
      chk("len_co0", 0, el, 16);
      chk("err_co0", 0, err[0], 4);
      chk("fvec_co0", 0, fvec[0], 3'b011);
      chk("fgot_co0", 0, fgot[0], 2'b00);
      chk("pass_co0", 0, pass[0], 0);

      fault[0] = 2;
      kick(0, k);
      wait_done(0, k, el);
      chk("err_inv", 0, err[0], 8);
      chk("fvec_inv", 0, fvec[0], 3'b000);
      chk("fgot_inv", 0, fgot[0], 2'b01);

      kick(1, k);
      wait_done(1, k, el);
      chk("len_p3", 1, el, 48);
      chk("err_sat", 1, err[1], 15);
      chk("pass_p3", 1, pass[1], 0);

      kick(2, k);
      wait_done(2, k, el);
      chk("len_s3", 2, el, 32);
      chk("pass_s3", 2, pass[2], 1);
    end

    // Start while busy (default build), then abort with reset.
    fault[0] = 0;
    kick(0, k);
    repeat (4) @(negedge clk);
    if (!LOOP) start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("busy_mid", 0, busy[0], 1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_done", 0, done[0], 0);
    chk("abort_vec", 0, {op1[0], op2[0], ci[0]}, 0);

    if (!LOOP) begin
      kick(0, k);
      wait_done(0, k, el);
      chk("len_rerun", 0, el, 16);
      chk("pass_rerun", 0, pass[0], 1);
    end else begin
      kick(0, k);
      repeat (19) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0, k, el);
      chk("len_loop", 0, el, 22);
      chk("pass_loop", 0, pass[0], 1);
      chk("err_loop", 0, err[0], 0);

      fault[0] = 2;
      kick(0, k);
      repeat (39) @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0, k, el);
      chk("len_loop_sat", 0, el, 42);
      chk("err_loop_sat", 0, err[0], 15);
      chk("pass_loop_sat", 0, pass[0], 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
